// File: rtl/flux_pkg.sv
// Shared definitions for the spectral-flux beat detector: FSM states, default widths
// and a constant-evaluable ceil(log2) helper.
package flux_pkg;

   localparam int unsigned DEFAULT_MAX_FLUX_LENGTH = 32;

   typedef enum logic [1:0] {
      StIdle,
      StCalc,
      StDecide
   } state_e;

   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < n) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/flux_history.sv
// Circular history of the last HIST_LEN flux values with an exact running sum
// and fill/warm tracking. Storage is a small register array.
module flux_history
   import flux_pkg::*;
#(
   parameter int unsigned WIDTH    = DEFAULT_MAX_FLUX_LENGTH,
   parameter int unsigned HIST_LEN = 8
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              i_wr,
   input  logic [WIDTH-1:0]                  i_data,
   output logic [WIDTH+clog2(HIST_LEN)-1:0]  o_sum,
   output logic                              o_warm
);

   localparam int unsigned AW = clog2(HIST_LEN);
   localparam int unsigned SW = WIDTH + AW;
   localparam int unsigned FW = AW + 1;

   logic [WIDTH-1:0] r_hist [HIST_LEN];
   logic [AW-1:0]    r_wr_ptr;
   logic [FW-1:0]    r_fill;
   logic [SW-1:0]    r_sum;
   logic [WIDTH-1:0] w_oldest;

   // The slot about to be overwritten holds the oldest value (zero during warm-up).
   assign w_oldest = r_hist[r_wr_ptr];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < HIST_LEN; i++) r_hist[i] <= '0;
         r_wr_ptr <= '0;
         r_fill   <= '0;
         r_sum    <= '0;
      end else if (i_wr) begin
         r_sum            <= r_sum - SW'(w_oldest) + SW'(i_data);
         r_hist[r_wr_ptr] <= i_data;
         r_wr_ptr         <= r_wr_ptr + AW'(1);
         if (r_fill != FW'(HIST_LEN)) r_fill <= r_fill + FW'(1);
      end
   end

   assign o_sum  = r_sum;
   assign o_warm = (r_fill == FW'(HIST_LEN));

endmodule

// File: rtl/flux_beat_detector.sv
// Beat detector: compares each new flux frame against a scaled moving average of the
// previous HIST_LEN frames and an absolute floor, with a refractory window.
module flux_beat_detector
   import flux_pkg::*;
#(
   parameter int unsigned MAX_FLUX_LENGTH = DEFAULT_MAX_FLUX_LENGTH,
   parameter int unsigned HIST_LEN        = 8,
   parameter int unsigned K_NUM           = 3,
   parameter int unsigned K_SHIFT         = 1,
   parameter int unsigned MIN_FLUX        = 64,
   parameter int unsigned REFRACT         = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         flux_valid,
   input  logic [MAX_FLUX_LENGTH-1:0]   flux_value,
   output logic                         beat,
   output logic [MAX_FLUX_LENGTH-1:0]   flux_avg,
   output logic [MAX_FLUX_LENGTH+2:0]   threshold,
   output logic                         warm,
   output logic [15:0]                  beat_count,
   output logic                         overrun
);

   localparam int unsigned W  = MAX_FLUX_LENGTH;
   localparam int unsigned TW = MAX_FLUX_LENGTH + 3;
   localparam int unsigned AW = clog2(HIST_LEN);
   localparam int unsigned SW = W + AW;
   localparam int unsigned RW = (REFRACT < 1) ? 1 : clog2(REFRACT + 1);

   state_e        r_state, w_state_next;
   logic [W-1:0]  r_cur, r_avg, r_flux_avg;
   logic [TW-1:0] r_thr, r_threshold;
   logic [RW-1:0] r_refr;
   logic [15:0]   r_beat_count;
   logic          r_beat, r_overrun;
   logic [SW-1:0] w_sum;
   logic [W-1:0]  w_avg;
   logic [TW-1:0] w_thr;
   logic          w_warm, w_hist_wr, w_hit;

   flux_history #(
      .WIDTH    (W),
      .HIST_LEN (HIST_LEN)
   ) u_history (
      .clk    (clk),
      .reset  (reset),
      .i_wr   (w_hist_wr),
      .i_data (r_cur),
      .o_sum  (w_sum),
      .o_warm (w_warm)
   );

   assign w_avg = W'(w_sum >> AW);
   assign w_thr = (TW'(w_avg) * TW'(K_NUM)) >> K_SHIFT;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= StIdle;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_hist_wr    = 1'b0;
      w_hit        = 1'b0;
      case (r_state)
         StIdle:   if (flux_valid) w_state_next = StCalc;
         StCalc:   w_state_next = StDecide;
         StDecide: begin
            w_state_next = StIdle;
            w_hist_wr    = 1'b1;
            w_hit        = w_warm && (r_refr == '0) && (TW'(r_cur) > r_thr)
                           && (r_cur >= W'(MIN_FLUX));
         end
         default:  w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cur        <= '0;
         r_avg        <= '0;
         r_thr        <= '0;
         r_flux_avg   <= '0;
         r_threshold  <= '0;
         r_refr       <= '0;
         r_beat_count <= '0;
         r_beat       <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         r_beat <= 1'b0;
         // A strobe outside IDLE is dropped; only the sticky flag records it.
         if (flux_valid && (r_state != StIdle)) r_overrun <= 1'b1;
         case (r_state)
            StIdle:   if (flux_valid) r_cur <= flux_value;
            StCalc: begin
               r_avg <= w_avg;
               r_thr <= w_thr;
            end
            StDecide: begin
               r_flux_avg  <= r_avg;
               r_threshold <= r_thr;
               if (w_hit) begin
                  r_beat       <= 1'b1;
                  r_beat_count <= r_beat_count + 16'd1;
                  r_refr       <= RW'(REFRACT);
               end else if (r_refr != '0) begin
                  r_refr <= r_refr - RW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign beat       = r_beat;
   assign flux_avg   = r_flux_avg;
   assign threshold  = r_threshold;
   assign warm       = w_warm;
   assign beat_count = r_beat_count;
   assign overrun    = r_overrun;

endmodule

// File: tb/tb_flux_beat_detector.sv
// Directed bench for flux_beat_detector: a queue-based frame model drives per-cycle
// output expectations, plus literal checks of the hand-computed scenario values.
module tb_flux_beat_detector;

   localparam int HIST = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        flux_valid;
   logic [31:0] flux_value;
   logic        beat;
   logic [31:0] flux_avg;
   logic [34:0] threshold;
   logic        warm;
   logic [15:0] beat_count;
   logic        overrun;

   flux_beat_detector dut (
      .clk        (clk),
      .reset      (reset),
      .flux_valid (flux_valid),
      .flux_value (flux_value),
      .beat       (beat),
      .flux_avg   (flux_avg),
      .threshold  (threshold),
      .warm       (warm),
      .beat_count (beat_count),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   bit running  = 0;

   // Model state: the frames seen since reset (missing ones count as zero).
   longint      mq[$];
   int          m_refr;
   logic        exp_beat, exp_warm, exp_overrun;
   logic [31:0] exp_avg;
   logic [34:0] exp_thr;
   logic [15:0] exp_cnt;
   logic        last_beat;
   logic [31:0] last_avg;
   logic [34:0] last_thr;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_refr      = 0;
      exp_beat    = 0;
      exp_warm    = 0;
      exp_overrun = 0;
      exp_avg     = 0;
      exp_thr     = 0;
      exp_cnt     = 0;
   endtask

   task automatic model_frame(input longint v);
      longint s, a, t;
      bit     w, hit;
      s = 0;
      foreach (mq[i]) s += mq[i];
      a   = s / HIST;
      t   = (a * 3) / 2;
      w   = (mq.size() == HIST);
      hit = w && (m_refr == 0) && (v > t) && (v >= 64);
      exp_avg  = a[31:0];
      exp_thr  = t[34:0];
      exp_beat = hit;
      if (hit) begin
         exp_cnt = exp_cnt + 16'd1;
         m_refr  = 2;
      end else if (m_refr > 0) begin
         m_refr--;
      end
      mq.push_back(v);
      if (mq.size() > HIST) void'(mq.pop_front());
      exp_warm = (mq.size() == HIST);
   endtask

   always @(negedge clk) begin
      if (running) begin
         check("beat", 64'(beat), 64'(exp_beat));
         check("flux_avg", 64'(flux_avg), 64'(exp_avg));
         check("threshold", 64'(threshold), 64'(exp_thr));
         check("warm", 64'(warm), 64'(exp_warm));
         check("beat_count", 64'(beat_count), 64'(exp_cnt));
         check("overrun", 64'(overrun), 64'(exp_overrun));
      end
   end

   // One frame; with dup set, a second strobe follows on the very next cycle.
   task automatic send(input logic [31:0] v, input bit dup, input logic [31:0] v2);
      @(posedge clk); #1;
      flux_valid = 1'b1;
      flux_value = v;
      @(posedge clk); #1;
      if (dup) flux_value = v2;
      else     flux_valid = 1'b0;
      @(posedge clk); #1;
      if (dup) begin
         flux_valid  = 1'b0;
         exp_overrun = 1'b1;
      end
      @(posedge clk); #1;
      model_frame(longint'(v));
      #3;
      last_beat = beat;
      last_avg  = flux_avg;
      last_thr  = threshold;
      @(posedge clk); #1;
      exp_beat = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b1;
      model_reset();
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic send_n(input int n, input logic [31:0] v);
      for (int i = 0; i < n; i++) send(v, 1'b0, 32'd0);
   endtask

   initial begin
      reset      = 1'b1;
      flux_valid = 1'b0;
      flux_value = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      running = 1;
      reset   = 1'b0;
      #2;
      check("rst_beat_count", 64'(beat_count), 64'd0);
      check("rst_warm", 64'(warm), 64'd0);

      // Reset mid-CALC, then a frame from empty history
      send_n(8, 32'd1000);
      check("pre_rst_avg", 64'(last_avg), 64'd875);
      @(posedge clk); #1;
      flux_valid = 1'b1;
      flux_value = 32'd4000;
      @(posedge clk); #1;
      flux_valid = 1'b0;
      reset      = 1'b1;
      model_reset();
      #1;
      check("midcalc_avg", 64'(flux_avg), 64'd0);
      check("midcalc_thr", 64'(threshold), 64'd0);
      check("midcalc_warm", 64'(warm), 64'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      send(32'd5000, 1'b0, 32'd0);
      check("post_rst_beat", 64'(last_beat), 64'd0);
      check("post_rst_avg", 64'(last_avg), 64'd0);

      // Warm-up
      do_reset();
      send_n(7, 32'd1000);
      send(32'd5000, 1'b0, 32'd0);
      check("warmup_nobeat", 64'(last_beat), 64'd0);
      send(32'd5000, 1'b0, 32'd0);
      check("warmup_beat", 64'(last_beat), 64'd1);
      check("warmup_avg", 64'(last_avg), 64'd1500);
      check("warmup_thr", 64'(last_thr), 64'd2250);
      check("warmup_count", 64'(beat_count), 64'd1);

      // Threshold edge: strict comparison
      do_reset();
      send_n(8, 32'd1000);
      send(32'd1500, 1'b0, 32'd0);
      check("edge_eq_beat", 64'(last_beat), 64'd0);
      check("edge_eq_thr", 64'(last_thr), 64'd1500);
      do_reset();
      send_n(8, 32'd1000);
      send(32'd1600, 1'b0, 32'd0);
      check("edge_above_beat", 64'(last_beat), 64'd1);

      // Refractory
      do_reset();
      send_n(8, 32'd1000);
      send(32'd3000, 1'b0, 32'd0);
      check("refr_first", 64'(last_beat), 64'd1);
      send(32'd3000, 1'b0, 32'd0);
      check("refr_sup1", 64'(last_beat), 64'd0);
      send(32'd3000, 1'b0, 32'd0);
      check("refr_sup2", 64'(last_beat), 64'd0);
      send(32'd10000, 1'b0, 32'd0);
      check("refr_after", 64'(last_beat), 64'd1);
      check("refr_avg", 64'(last_avg), 64'd1750);
      check("refr_thr", 64'(last_thr), 64'd2625);
      check("refr_count", 64'(beat_count), 64'd2);

      // Absolute floor
      do_reset();
      send_n(8, 32'd0);
      send(32'd50, 1'b0, 32'd0);
      check("floor_below", 64'(last_beat), 64'd0);
      do_reset();
      send_n(8, 32'd0);
      send(32'd100, 1'b0, 32'd0);
      check("floor_above", 64'(last_beat), 64'd1);

      // Overrun: second strobe dropped, fill advances once
      do_reset();
      send(32'd1000, 1'b1, 32'd9000);
      check("ovr_set", 64'(overrun), 64'd1);
      send_n(6, 32'd0);
      check("ovr_fill7", 64'(warm), 64'd0);
      send(32'd0, 1'b0, 32'd0);
      check("ovr_fill8", 64'(warm), 64'd1);
      check("ovr_sticky", 64'(overrun), 64'd1);
      do_reset();
      #1;
      check("ovr_cleared", 64'(overrun), 64'd0);

      repeat (2) @(posedge clk);
      #1;
      running = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
